// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10
  } hs_state_e;

  localparam int unsigned CDC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop level synchroniser for a single asynchronous bit into the clk domain.
module cdc_sync
  import cdc_pkg::*;
#(
  parameter int unsigned pSTAGES = CDC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [pSTAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[pSTAGES-2:0], d};
    end
  end

  assign q = sync_reg[pSTAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of the four-phase req/ack handshake: accepts a word, holds it on a
// registered bus, and runs req high / ack high / req low / ack low to completion.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int unsigned pDATA_W = 32,
  parameter int unsigned pSTAGES = CDC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               send_valid,
  output logic               send_ready,
  input  logic [pDATA_W-1:0] send_data,
  output logic               xfer_req,
  output logic [pDATA_W-1:0] xfer_data,
  input  logic               xfer_ack_async,
  output logic               send_done,
  output logic               busy,
  output logic               err_proto,
  input  logic               err_clr
);

  hs_state_e          state_reg, state_next;
  logic               req_reg, req_next;
  logic [pDATA_W-1:0] data_reg, data_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               ack_prev_reg;
  logic               ack_s;

  cdc_sync #(
    .pSTAGES (pSTAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (xfer_ack_async),
    .q     (ack_s)
  );

  // A still-high ack in IDLE means the far side has not released; hold off new words.
  assign send_ready = (state_reg == IDLE) && !ack_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      data_reg     <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ack_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      ack_prev_reg <= ack_s;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (send_valid && send_ready) begin
          data_next  = send_data;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        req_next = 1'b1;
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = REL;
        end
      end
      REL: begin
        req_next = 1'b0;
        if (!ack_s) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // An ack edge with no request outstanding is a protocol violation; set beats clear.
  always_comb begin
    err_next = err_reg;
    if (err_clr) begin
      err_next = 1'b0;
    end
    if ((state_reg == IDLE) && ack_s && !ack_prev_reg) begin
      err_next = 1'b1;
    end
  end

  assign xfer_req  = req_reg;
  assign xfer_data = data_reg;
  assign send_done = done_reg;
  assign busy      = (state_reg != IDLE);
  assign err_proto = err_reg;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: instance 0 uses two ack stages, instance 1 uses three.
module tb_cdc_hs_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv    [2];
  logic [31:0] sd    [2];
  logic        ready [2];
  logic        req   [2];
  logic [31:0] xd    [2];
  logic        ack   [2];
  logic        done  [2];
  logic        busy  [2];
  logic        err   [2];
  logic        eclr  [2];
  logic        dest_en  [2];
  int          dest_cnt [2];
  logic [31:0] dest_log [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cdc_hs_tx #(.pDATA_W(32), .pSTAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .send_valid(sv[0]), .send_ready(ready[0]),
    .send_data(sd[0]), .xfer_req(req[0]), .xfer_data(xd[0]),
    .xfer_ack_async(ack[0]), .send_done(done[0]), .busy(busy[0]),
    .err_proto(err[0]), .err_clr(eclr[0])
  );

  cdc_hs_tx #(.pDATA_W(32), .pSTAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .send_valid(sv[1]), .send_ready(ready[1]),
    .send_data(sd[1]), .xfer_req(req[1]), .xfer_data(xd[1]),
    .xfer_ack_async(ack[1]), .send_done(done[1]), .busy(busy[1]),
    .err_proto(err[1]), .err_clr(eclr[1])
  );

  // Destination model: ack rises 3 cycles after req is seen, falls 3 cycles after req drops.
  task automatic dest_step(input int s);
    if (req[s] && !ack[s]) begin
      dest_cnt[s]++;
      if (dest_cnt[s] == 3) begin
        ack[s] = 1'b1;
        dest_cnt[s] = 0;
        if (s == 0) dest_log.push_back(xd[s]);
      end
    end else if (!req[s] && ack[s]) begin
      dest_cnt[s]++;
      if (dest_cnt[s] == 3) begin
        ack[s] = 1'b0;
        dest_cnt[s] = 0;
      end
    end else begin
      dest_cnt[s] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (dest_en[0]) dest_step(0);
  end

  initial forever begin
    @(posedge clk); #1;
    if (dest_en[1]) dest_step(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // One full handshake; fall_exp is counted from accept, done_exp from the req fall.
  task automatic run_transfer(input int s, input logic [31:0] w,
                              input int fall_exp, input int done_exp, input string nm);
    int fall_k, done_k, pulses;
    logic data_bad;
    fall_k = -1; done_k = -1; pulses = 0; data_bad = 1'b0;
    total++;
    if (ready[s] !== 1'b1) begin
      bad++; $display("FAIL %s_ready: got %b expected 1", nm, ready[s]);
    end
    sd[s] = w; sv[s] = 1'b1;
    @(posedge clk); #1;
    sv[s] = 1'b0;
    $display("%s: accept data=%h req=%b", nm, xd[s], req[s]);
    total++;
    if (req[s] !== 1'b1 || xd[s] !== w) begin
      bad++; $display("FAIL %s_accept: got req=%b data=%h expected req=1 data=%h", nm, req[s], xd[s], w);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (req[s] === 1'b0 && fall_k < 0) fall_k = k;
      if (done[s] === 1'b1) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
      if (busy[s] === 1'b1 && xd[s] !== w) data_bad = 1'b1;
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    $display("%s: req_fall=%0d done=%0d pulses=%0d", nm, fall_k, done_k, pulses);
    total++;
    if (fall_k !== fall_exp) begin
      bad++; $display("FAIL %s_req_fall: got cycle %0d expected %0d", nm, fall_k, fall_exp);
    end
    total++;
    if (done_k < 0 || (done_k - fall_k) !== done_exp) begin
      bad++; $display("FAIL %s_done_time: got %0d after fall expected %0d", nm, done_k - fall_k, done_exp);
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL %s_done_pulses: got %0d expected 1", nm, pulses);
    end
    total++;
    if (data_bad !== 1'b0 || xd[s] !== w) begin
      bad++; $display("FAIL %s_data_hold: got %h (unstable=%b) expected %h", nm, xd[s], data_bad, w);
    end
    total++;
    if (busy[s] !== 1'b0 || ready[s] !== 1'b1) begin
      bad++; $display("FAIL %s_idle_after: got busy=%b ready=%b expected 0/1", nm, busy[s], ready[s]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b0; sd[s] = '0; ack[s] = 1'b0; eclr[s] = 1'b0;
      dest_en[s] = 1'b1; dest_cnt[s] = 0;
    end
    #12;
    $display("reset: req=%b data=%h busy=%b done=%b err=%b", req[0], xd[0], busy[0], done[0], err[0]);
    total++;
    if (req[0] !== 1'b0 || xd[0] !== 32'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got req=%b data=%h busy=%b done=%b err=%b expected all 0",
                      req[0], xd[0], busy[0], done[0], err[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b1 || ready[1] !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b/%b expected 1/1", ready[0], ready[1]);
    end
  endtask

  task automatic test_basic();
    run_transfer(0, 32'hDEADBEEF, 5, 5, "basic");
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int idx, done_cnt, b2b_cnt;
    logic pre, pre_done, prev_req, stable_bad, ready_bad;
    logic [31:0] prev_xd;
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
    idx = 0; done_cnt = 0; b2b_cnt = 0;
    stable_bad = 1'b0; ready_bad = 1'b0;
    prev_req = req[0]; prev_xd = xd[0];
    dest_log.delete();
    sd[0] = words[0]; sv[0] = 1'b1;
    for (int k = 0; k < 80; k++) begin
      pre = sv[0] && ready[0];
      pre_done = done[0];
      @(posedge clk); #1;
      if (done[0] === 1'b1) done_cnt++;
      if (prev_req && req[0] && xd[0] !== prev_xd) stable_bad = 1'b1;
      if (ready[0] && busy[0]) ready_bad = 1'b1;
      if (pre) begin
        $display("b2b: accept word %0d data=%h in_done_cycle=%b", idx, xd[0], pre_done);
        total++;
        if (xd[0] !== words[idx] || req[0] !== 1'b1) begin
          bad++; $display("FAIL b2b_accept%0d: got data=%h req=%b expected %h/1", idx, xd[0], req[0], words[idx]);
        end
        if (idx > 0 && pre_done) b2b_cnt++;
        idx++;
        if (idx == 3) sv[0] = 1'b0;
        else sd[0] = words[idx];
      end
      prev_req = req[0]; prev_xd = xd[0];
      if (done_cnt == 3) break;
    end
    total++;
    if (idx !== 3 || done_cnt !== 3) begin
      bad++; $display("FAIL b2b_count: got accepts=%0d dones=%0d expected 3/3", idx, done_cnt);
    end
    total++;
    if (b2b_cnt !== 2) begin
      bad++; $display("FAIL b2b_done_cycle_accepts: got %0d expected 2", b2b_cnt);
    end
    total++;
    if (stable_bad !== 1'b0 || ready_bad !== 1'b0) begin
      bad++; $display("FAIL b2b_stability: got data_changed=%b ready_while_busy=%b expected 0/0", stable_bad, ready_bad);
    end
    total++;
    if (dest_log.size() !== 3 || dest_log[0] !== 32'h1 || dest_log[1] !== 32'h2 || dest_log[2] !== 32'h3) begin
      bad++; $display("FAIL b2b_order: got %0d words expected 1,2,3 in order", dest_log.size());
    end
  endtask

  task automatic test_ignored_valid();
    int rises, pulses;
    logic prev_req, data_bad;
    rises = 0; pulses = 0; data_bad = 1'b0;
    sd[0] = 32'h11111111; sv[0] = 1'b1;
    @(posedge clk); #1;
    prev_req = req[0];
    sd[0] = 32'hAAAA5555;
    for (int k = 0; k < 40; k++) begin
      if (busy[0]) sv[0] = ~sv[0];
      else sv[0] = 1'b0;
      @(posedge clk); #1;
      if (req[0] && !prev_req) rises++;
      if (xd[0] !== 32'h11111111) data_bad = 1'b1;
      if (done[0] === 1'b1) pulses++;
      prev_req = req[0];
      if (pulses > 0 && !busy[0] && k > 12) break;
    end
    sv[0] = 1'b0;
    @(posedge clk); #1;
    $display("ignored: data=%h extra_rises=%0d dones=%0d", xd[0], rises, pulses);
    total++;
    if (rises !== 0) begin
      bad++; $display("FAIL ignored_req_rise: got %0d extra rises expected 0", rises);
    end
    total++;
    if (data_bad !== 1'b0 || xd[0] !== 32'h11111111) begin
      bad++; $display("FAIL ignored_data: got %h expected 11111111", xd[0]);
    end
    total++;
    if (pulses !== 1 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL ignored_done: got pulses=%0d busy=%b expected 1/0", pulses, busy[0]);
    end
  endtask

  task automatic test_protocol_error();
    dest_en[0] = 1'b0;
    ack[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (err[0] !== 1'b0) begin
      bad++; $display("FAIL perr_edge1: got err=%b expected 0", err[0]);
    end
    @(posedge clk); #1;
    total++;
    if (err[0] !== 1'b0 || ready[0] !== 1'b0) begin
      bad++; $display("FAIL perr_edge2: got err=%b ready=%b expected 0/0", err[0], ready[0]);
    end
    sd[0] = 32'hBAD0BAD0; sv[0] = 1'b1;
    @(posedge clk); #1;
    $display("perr: err=%b ready=%b busy=%b req=%b", err[0], ready[0], busy[0], req[0]);
    total++;
    if (err[0] !== 1'b1 || ready[0] !== 1'b0) begin
      bad++; $display("FAIL perr_edge3: got err=%b ready=%b expected 1/0", err[0], ready[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (busy[0] !== 1'b0 || req[0] !== 1'b0) begin
      bad++; $display("FAIL perr_no_accept: got busy=%b req=%b expected 0/0", busy[0], req[0]);
    end
    ack[0] = 1'b0; sv[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b0) begin
      bad++; $display("FAIL perr_ready_hold: got %b expected 0", ready[0]);
    end
    @(posedge clk); #1;
    total++;
    if (ready[0] !== 1'b1 || err[0] !== 1'b1) begin
      bad++; $display("FAIL perr_resume: got ready=%b err=%b expected 1/1", ready[0], err[0]);
    end
    eclr[0] = 1'b1;
    @(posedge clk); #1;
    eclr[0] = 1'b0;
    $display("perr: after clear err=%b", err[0]);
    total++;
    if (err[0] !== 1'b0) begin
      bad++; $display("FAIL perr_clear: got err=%b expected 0", err[0]);
    end
    dest_en[0] = 1'b1;
  endtask

  task automatic test_reset_mid();
    sd[0] = 32'h12345678; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req[0] !== 1'b1 || xd[0] !== 32'h12345678) begin
      bad++; $display("FAIL rmid_in_req: got req=%b data=%h expected 1/12345678", req[0], xd[0]);
    end
    rst_n = 1'b0;
    #1;
    $display("rmid: req=%b data=%h busy=%b done=%b", req[0], xd[0], busy[0], done[0]);
    total++;
    if (req[0] !== 1'b0 || xd[0] !== 32'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      bad++; $display("FAIL rmid_async: got req=%b data=%h busy=%b done=%b expected 0/0/0/0",
                      req[0], xd[0], busy[0], done[0]);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_transfer(0, 32'hCAFEF00D, 5, 5, "rmid_new");
  endtask

  task automatic test_stages3();
    run_transfer(1, 32'hDEADBEEF, 6, 6, "stages3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_valid();
    test_protocol_error();
    test_reset_mid();
    test_stages3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
